regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter_if.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus: per-requester valid/rd/rdv with a one-hot ready back.
interface regfile_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [5*NUM_REQ-1:0]    req_rd;
  logic [XLEN*NUM_REQ-1:0] req_rdv;
  logic [NUM_REQ-1:0]      req_ready;

  modport master (
    output req_valid,
    output req_rd,
    output req_rdv,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_rdv,
    output req_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the register file write port.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (index 0 wins).
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave req,
  output logic [4:0]          rd,
  output logic [XLEN-1:0]     rdv,
  output logic                reg_wen,
  output logic [2:0]          grant_id,
  output logic [31:0]         pending_mask
);

  logic [7:0]      valid_pad;
  logic            gnt_found;
  logic [2:0]      gnt_idx;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_rdv;

  logic [4:0]      rd_q;
  logic [XLEN-1:0] rdv_q;
  logic            reg_wen_q;
  logic [2:0]      grant_id_q;

  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_REQ-1:0]   = req.req_valid;
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [2:0] ptr_q;
  logic [2:0] ptr_d;
  logic [3:0] cand;

  // Search upward from ptr_q, wrapping at NUM_REQ; first valid index wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = 4'(ptr_q) + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!gnt_found && valid_pad[cand[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found) ptr_d = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && valid_pad[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
      end
    end
  end
`endif

  // Ready is gated by rst_n so no handshake can complete while in reset.
  always_comb begin
    req.req_ready = '0;
    sel_rd        = '0;
    sel_rdv       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        req.req_ready[i] = rst_n & gnt_found;
        sel_rd           = req.req_rd[5*i +: 5];
        sel_rdv          = req.req_rdv[XLEN*i +: XLEN];
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req.req_valid[i] && !req.req_ready[i]) pending_mask[req.req_rd[5*i +: 5]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  // rd/rdv/grant_id hold when idle; x0 writes load but keep reg_wen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rdv_q      <= '0;
      reg_wen_q  <= 1'b0;
      grant_id_q <= '0;
    end else if (gnt_found) begin
      rd_q       <= sel_rd;
      rdv_q      <= sel_rdv;
      reg_wen_q  <= (sel_rd != 5'd0);
      grant_id_q <= gnt_idx;
    end else begin
      reg_wen_q  <= 1'b0;
    end
  end

  assign rd       = rd_q;
  assign rdv      = rdv_q;
  assign reg_wen  = reg_wen_q;
  assign grant_id = grant_id_q;

endmodule
